// File: rtl/cv32e41p_fetch_queue.sv
// Instruction fetch queue: OBI master with DEPTH-entry response FIFO,
// redirect handling and stale-response discarding.
module cv32e41p_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic {RUN, BRANCH_WAIT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   held_addr_q;
    logic [31:0]   target;
    logic          held_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] fifo_q, fifo_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_rdata [DEPTH];
    logic          mem_err   [DEPTH];
    logic          gnt_fire;
    logic          push;
    logic          pop;
    logic          space;
    logic          stale_gnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign target        = {branch_addr_i[31:2], 2'b00};
    assign space         = ({1'b0, out_q} + {1'b0, fifo_q}) < DEPTH_C;
    assign gnt_fire      = instr_req_o & instr_gnt_i;
    assign fetch_valid_o = (fifo_q != '0) & ~branch_i;
    assign pop           = fetch_valid_o & fetch_ready_i;
    assign push          = instr_rvalid_i & ~branch_i & (discard_q == '0);
    assign fetch_rdata_o = (fifo_q != '0) ? mem_rdata[rd_ptr_q] : '0;
    assign fetch_err_o   = (fifo_q != '0) & mem_err[rd_ptr_q];
    assign busy_o        = (out_q != '0) | (state_q == BRANCH_WAIT);

    // A request left ungranted is re-presented unchanged; a redirect during
    // that hold turns the eventual grant into a stale transaction.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        instr_req_o  = 1'b0;
        instr_addr_o = addr_q;
        stale_gnt    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (held_q) begin
                    instr_req_o  = 1'b1;
                    instr_addr_o = held_addr_q;
                    if (branch_i) begin
                        addr_d    = target;
                        stale_gnt = instr_gnt_i;
                        if (!instr_gnt_i) state_d = BRANCH_WAIT;
                    end else if (instr_gnt_i) begin
                        addr_d = held_addr_q + 32'd4;
                    end
                end else begin
                    instr_req_o  = req_i & space;
                    instr_addr_o = branch_i ? target : addr_q;
                    if (branch_i) addr_d = target;
                    if (instr_req_o && instr_gnt_i) addr_d = instr_addr_o + 32'd4;
                end
            end
            BRANCH_WAIT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = held_addr_q;
                stale_gnt    = instr_gnt_i;
                if (branch_i) addr_d = target;
                if (instr_gnt_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        out_d    = out_q + CW'(gnt_fire) - CW'(instr_rvalid_i);
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (branch_i) begin
            discard_d = out_q - CW'(instr_rvalid_i) + CW'(stale_gnt);
            fifo_d    = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else begin
            discard_d = discard_q - CW'(instr_rvalid_i & (discard_q != '0)) + CW'(stale_gnt);
            fifo_d    = fifo_q + CW'(push) - CW'(pop);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            addr_q    <= '0;
            held_q    <= 1'b0;
            out_q     <= '0;
            fifo_q    <= '0;
            discard_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            held_q    <= instr_req_o & ~instr_gnt_i;
            out_q     <= out_d;
            fifo_q    <= fifo_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Datapath storage carries no reset; validity comes from held_q and fifo_q.
    always_ff @(posedge clk) begin
        if (instr_req_o) held_addr_q <= instr_addr_o;
        if (push) begin
            mem_rdata[wr_ptr_q] <= instr_rdata_i;
            mem_err[wr_ptr_q]   <= instr_err_i;
        end
    end

endmodule

// File: tb/tb_cv32e41p_fetch_queue.sv
// Self-checking bench for cv32e41p_fetch_queue: OBI memory model plus
// scoreboard of expected fetched words.
module tb_cv32e41p_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        fetch_ready_i = 1'b0;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    cv32e41p_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_ready_i (fetch_ready_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .fetch_err_o   (fetch_err_o),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .instr_err_i   (instr_err_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] gnt_log[$];
    int          rd_idx = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        ready_en = 1'b0;
    logic [31:0] err_addr = 32'h1;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.data = word_of(base + 32'(4 * k));
            e.err  = ((base + 32'(4 * k)) == err_addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (rd_idx < exp_q.size() && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 32'(rd_idx), 32'(exp_q.size()));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n         = 1'b0;
        req_i         = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_gnt_i   = 1'b0;
        ready_en      = 1'b0;
        lat           = 1;
        err_addr      = 32'h1;
        exp_q.delete();
        #2;
        chk("rst_req",   32'(instr_req_o),   0);
        chk("rst_valid", 32'(fetch_valid_o), 0);
        chk("rst_err",   32'(fetch_err_o),   0);
        chk("rst_busy",  32'(busy_o),        0);
        chk("rst_rdata", fetch_rdata_o,      0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // OBI memory model and fetch consumer.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = word_of(pend_q[0].addr);
                instr_err_i    = (pend_q[0].addr == err_addr);
                void'(pend_q.pop_front());
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = '0;
                instr_err_i    = 1'b0;
            end
            fetch_ready_i = ready_en && (rd_idx < exp_q.size());
            @(negedge clk);
            if (!rst_n) begin
                pend_q.delete();
                gnt_log.delete();
                rd_idx = 0;
            end else begin
                if (instr_req_o && instr_gnt_i) begin
                    gnt_log.push_back(instr_addr_o);
                    pend_q.push_back('{instr_addr_o, cyc + lat});
                end
                if (fetch_valid_o && fetch_ready_i) begin
                    chk("pop_data", fetch_rdata_o, exp_q[rd_idx].data);
                    chk("pop_err", 32'(fetch_err_o), 32'(exp_q[rd_idx].err));
                    rd_idx++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Boot from a misaligned redirect target.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h0000_1002;
        push_exp(32'h1000, 3);
        @(negedge clk);
        chk("boot_addr0", instr_addr_o, 32'h1000);
        chk("boot_req0", 32'(instr_req_o), 1);
        chk("boot_vld_c0", 32'(fetch_valid_o), 0);
        @(posedge clk); #1; branch_i = 1'b0;
        @(negedge clk);
        chk("boot_addr1", instr_addr_o, 32'h1004);
        chk("boot_vld_c1", 32'(fetch_valid_o), 0);
        chk("boot_busy", 32'(busy_o), 1);
        @(negedge clk);
        chk("boot_vld_c2", 32'(fetch_valid_o), 1);
        chk("boot_data_c2", fetch_rdata_o, word_of(32'h1000));
        drain("boot_drain");
        chk("boot_log0", log_at(0), 32'h1000);
        chk("boot_log1", log_at(1), 32'h1004);
        chk("boot_log2", log_at(2), 32'h1008);

        // Backpressure: FIFO plus outstanding limit to DEPTH.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h100;
        @(posedge clk); #1; branch_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_gnts", 32'(gnt_log.size()), 2);
        @(negedge clk);
        chk("bp_req_off", 32'(instr_req_o), 0);
        chk("bp_valid", 32'(fetch_valid_o), 1);
        @(posedge clk); #1;
        push_exp(32'h100, 1);
        ready_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_pops", 32'(rd_idx), 1);
        chk("bp_gnts_after", 32'(gnt_log.size()), 3);
        chk("bp_log2", log_at(2), 32'h108);
        @(negedge clk);
        chk("bp_req_off2", 32'(instr_req_o), 0);

        // Redirect while a request is held ungranted.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b0; ready_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h2000;
        @(negedge clk);
        chk("held_addr_a", instr_addr_o, 32'h2000);
        chk("held_req_a", 32'(instr_req_o), 1);
        @(posedge clk); #1;
        branch_addr_i = 32'h3000;
        push_exp(32'h3000, 2);
        @(negedge clk);
        chk("held_addr_b", instr_addr_o, 32'h2000);
        @(posedge clk); #1;
        branch_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        chk("held_addr_c", instr_addr_o, 32'h2000);
        chk("held_req_c", 32'(instr_req_o), 1);
        chk("held_busy", 32'(busy_o), 1);
        @(posedge clk); #1;
        instr_gnt_i = 1'b1;
        @(negedge clk);
        chk("held_addr_d", instr_addr_o, 32'h2000);
        @(posedge clk); #1;
        req_i = 1'b1;
        drain("held_drain");
        chk("held_log0", log_at(0), 32'h2000);
        chk("held_log1", log_at(1), 32'h3000);

        // Redirect with two transactions outstanding.
        do_reset();
        lat = 3;
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h100;
        @(posedge clk); #1; branch_i = 1'b0;
        @(posedge clk); #1;
        branch_i = 1'b1; branch_addr_i = 32'h400;
        push_exp(32'h400, 2);
        @(negedge clk);
        chk("stale_req_off", 32'(instr_req_o), 0);
        chk("stale_busy", 32'(busy_o), 1);
        @(posedge clk); #1; branch_i = 1'b0;
        drain("stale_drain");
        chk("stale_log1", log_at(1), 32'h104);
        chk("stale_log2", log_at(2), 32'h400);

        // Bus error tagged on one word only.
        do_reset();
        err_addr = 32'h10;
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'h8;
        push_exp(32'h8, 4);
        @(posedge clk); #1; branch_i = 1'b0;
        drain("err_drain");

        // Address wrap at the top of memory.
        do_reset();
        req_i = 1'b1; instr_gnt_i = 1'b1; ready_en = 1'b1;
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFE;
        push_exp(32'hFFFF_FFFC, 2);
        @(negedge clk);
        chk("wrap_addr0", instr_addr_o, 32'hFFFF_FFFC);
        @(posedge clk); #1; branch_i = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", instr_addr_o, 32'h0000_0000);
        drain("wrap_drain");
        chk("wrap_log1", log_at(1), 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cv32e41p_fetch_queue.md
CV32E41P_FETCH_QUEUE -- requirements
Module: cv32e41p_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning FIFO entries and max outstanding OBI transactions (legal 2..4).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
REQ-003 SHALL have: req_i  in  1  fetch enable from core controller.
REQ-004 SHALL have: branch_i  in  1  redirect strobe; branch_addr_i  in  32  redirect target.
REQ-005 SHALL have: fetch_ready_i  in  1  consumer accepts head word; fetch_valid_o  out  1  head word valid; fetch_rdata_o  out  32  head word; fetch_err_o  out  1  head word bus error.
REQ-006 SHALL have OBI master: instr_req_o  out  1; instr_addr_o  out  32; instr_gnt_i  in  1; instr_rvalid_i  in  1; instr_rdata_i  in  32; instr_err_i  in  1.
REQ-007 SHALL have: busy_o  out  1  transactions outstanding or redirect pending.

Function
REQ-008 SHALL fetch word-aligned only: every instr_addr_o has bits [1:0] = 2'b00; redirect target used as {branch_addr_i[31:2],2'b00}.
REQ-009 SHALL keep fetch pointer addr_q; each cycle with instr_req_o & instr_gnt_i, addr_q <= instr_addr_o + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-010 SHALL keep outstanding count out_q (granted, no rvalid yet): +1 on req&gnt, -1 on rvalid, both same cycle -> unchanged.
REQ-011 SHALL keep FIFO of DEPTH entries {rdata, err}; count fifo_q.
REQ-012 SHALL in state RUN assert instr_req_o = req_i & (out_q + fifo_q < DEPTH), except when OBI hold (REQ-013) forces it high.
REQ-013 SHALL obey OBI: once instr_req_o is high and not granted, instr_req_o stays high and instr_addr_o stable until instr_gnt_i, regardless of req_i or branch_i.
REQ-014 SHALL have FSM states RUN, BRANCH_WAIT; reset state RUN.
REQ-015 RUN, branch_i, no held request: instr_addr_o = aligned branch_addr_i same cycle; gnt that cycle belongs to new stream; addr_q <= target+4 if granted else target.
REQ-016 RUN, branch_i, held request: keep held address; latch target into addr_q; -> BRANCH_WAIT.
REQ-017 BRANCH_WAIT: instr_req_o = 1 with held address; on gnt -> RUN, that transaction counted as stale; next request uses latched target. branch_i in BRANCH_WAIT overwrites latched target.
REQ-018 SHALL on branch_i flush FIFO (fifo_q <= 0, ignoring fetch_ready_i that cycle) and set discard_q <= out_q - rvalid (+1 only in BRANCH_WAIT case when gnt that cycle).
REQ-019 rvalid arriving in the branch cycle SHALL be dropped.
REQ-020 rvalid with discard_q > 0 SHALL be dropped and decrement discard_q; otherwise pushed to FIFO tail with instr_err_i.
REQ-021 fetch_valid_o = (fifo_q != 0) & ~branch_i; latency rvalid -> fetch_valid_o = 1 cycle; no combinational bypass.
REQ-022 Pop on fetch_valid_o & fetch_ready_i; simultaneous push and pop on full FIFO SHALL be legal; push into full FIFO without pop SHALL be impossible by REQ-012.
REQ-023 busy_o = (out_q != 0) | (state == BRANCH_WAIT).
REQ-024 req_i low SHALL block new requests only; outstanding responses still accepted into FIFO.

Reset
REQ-025 On rst_n low: state RUN, addr_q 0, out_q 0, fifo_q 0, discard_q 0; instr_req_o 0, fetch_valid_o 0, fetch_err_o 0, busy_o 0, fetch_rdata_o 0.
REQ-026 Reset mid-transaction SHALL discard all state; responses after reset release to pre-reset requests are not the bench's concern (memory also reset).

Verification
REQ-027 Boot: branch_i with 0x0000_1002, gnt always 1, rvalid 1 cycle later -> addresses 0x1000,0x1004,0x1008; fetch_valid_o 2 cycles after first req; words in order.
REQ-028 Backpressure: fetch_ready_i=0, DEPTH=2 -> exactly 2 grants then instr_req_o 0; one pop -> exactly one new request.
REQ-029 Held redirect: req at 0x2000, gnt low 3 cycles, branch_i to 0x3000 in cycle 1 -> addr stays 0x2000 until gnt, next request 0x3000, 0x2000 response dropped.
REQ-030 Stale drop: 2 outstanding (0x100,0x104), branch_i to 0x400 -> both responses dropped, first fetch_rdata_o from 0x400.
REQ-031 Error: instr_err_i=1 with rvalid for 0x10 -> fetch_err_o=1 with that word only.
REQ-032 Wrap: branch to 0xFFFF_FFFC, gnt 1 -> next address 0x0000_0000.
